cpu_bus_ctrl: RTL and testbench

- Central SCC68070 bus cycle controller for the CD-i MONO1 top level.
- Decodes each CPU access and drives the peripheral chip selects (MCD212, CDIC, slave 68HC05, NVRAM).
- Sequences the cycle: fixed wait states, the MCD212 ack, and the slave DTACK edge handshake.
- Produces a single-cycle bus_ack or bus_err. It also generates the delayed slave IRQ pulse and runs a watchdog timeout.

---
 rtl/cpu_bus_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_cpu_bus_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_ctrl.sv
// ============================================================================
// cpu_bus_ctrl
// ----------------------------------------------------------------------------
// SCC68070 bus cycle controller for the CD-i MONO1 top level.
// It decodes each CPU access into one of the peripheral regions and drives
// the matching chip select. It then sequences the cycle through
// IDLE -> WAIT -> DONE -> HOLD and returns a one-cycle bus_ack or bus_err.
// It also produces the delayed one-cycle IRQ request to the slave 68HC05.
//
// Optional feature macro: BUS_TIMEOUT_EN
//   defined   : a WAIT lasting TIMEOUT cycles without completion ends with a
//               one-cycle bus_err (chip select dropped in DONE).
//   undefined : WAIT never times out.
//
// Ports
//   clk           in   system clock
//   reset         in   synchronous, active-high reset
//   addr[22:0]    in   CPU word address (byte address bits 23:1)
//   as            in   address strobe, active high
//   uds / lds     in   upper / lower data strobe
//   write_strobe  in   1 = write cycle (does not affect decode or timing)
//   mcd212_ack    in   MCD212 cycle complete (level)
//   slave_dtack   in   slave DTACK; a 0->1 edge completes a slave cycle
//   cs_mcd212     out  MCD212 select
//   cs_cdic       out  CDIC select
//   cs_slave      out  slave select
//   cs_nvram      out  NVRAM select
//   bus_ack       out  one-cycle cycle-complete to the CPU
//   bus_err       out  one-cycle bus error to the CPU
//   slave_irq     out  one-cycle IRQ request to the 68HC05
// All outputs are registered.
// ============================================================================
module cpu_bus_ctrl #(
    parameter int unsigned CDIC_WAIT       = 32'd1,
    parameter int unsigned NVRAM_WAIT      = 32'd2,
    parameter int unsigned OPEN_WAIT       = 32'd1,
    parameter int unsigned SLAVE_IRQ_DELAY = 32'd20,
    parameter int unsigned TIMEOUT         = 32'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [22:0] addr,
    input  logic        as,
    input  logic        uds,
    input  logic        lds,
    input  logic        write_strobe,
    input  logic        mcd212_ack,
    input  logic        slave_dtack,
    output logic        cs_mcd212,
    output logic        cs_cdic,
    output logic        cs_slave,
    output logic        cs_nvram,
    output logic        bus_ack,
    output logic        bus_err,
    output logic        slave_irq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        RG_MCD212 = 3'd0,
        RG_CDIC   = 3'd1,
        RG_SLAVE  = 3'd2,
        RG_NVRAM  = 3'd3,
        RG_OPEN   = 3'd4,
        RG_ERR    = 3'd5
    } region_t;

    localparam logic [7:0] CDIC_WAIT_C  = 8'(CDIC_WAIT);
    localparam logic [7:0] NVRAM_WAIT_C = 8'(NVRAM_WAIT);
    localparam logic [7:0] OPEN_WAIT_C  = 8'(OPEN_WAIT);
    localparam logic [7:0] IRQ_DELAY_C  = 8'(SLAVE_IRQ_DELAY);
    localparam logic [8:0] TIMEOUT_C    = 9'(TIMEOUT);
`ifdef BUS_TIMEOUT_EN
    localparam logic       TIMEOUT_EN_C = 1'b1;
`else
    localparam logic       TIMEOUT_EN_C = 1'b0;
`endif

    // Map a word address onto its peripheral region (decoded on the byte address).
    function automatic region_t decode_region(input logic [22:0] word_addr);
        logic [23:0] byte_addr;
        region_t     rg;
        byte_addr = {word_addr, 1'b0};
        if ((byte_addr <= 24'h27FFFF) ||
            ((byte_addr >= 24'h400000) && (byte_addr <= 24'h5FFFFF))) begin
            rg = RG_MCD212;
        end else if (byte_addr[23:16] == 8'h30) begin
            rg = RG_CDIC;
        end else if (byte_addr[23:16] == 8'h31) begin
            rg = RG_SLAVE;
        end else if (byte_addr[23:16] == 8'h32) begin
            rg = RG_NVRAM;
        end else if (((byte_addr >= 24'h600000) && (byte_addr <= 24'hCFFFFF)) ||
                     (byte_addr >= 24'hF00000)) begin
            rg = RG_ERR;
        end else begin
            rg = RG_OPEN;
        end
        return rg;
    endfunction

    // Chip-select pattern {mcd212, cdic, slave, nvram} for a region.
    function automatic logic [3:0] cs_for_region(input region_t rg);
        logic [3:0] cs;
        case (rg)
            RG_MCD212: cs = 4'b1000;
            RG_CDIC:   cs = 4'b0100;
            RG_SLAVE:  cs = 4'b0010;
            RG_NVRAM:  cs = 4'b0001;
            default:   cs = 4'b0000;
        endcase
        return cs;
    endfunction

    state_t      state_r;
    region_t     region_r;
    logic [7:0]  wait_cnt_r;
    logic [7:0]  irq_cnt_r;
    logic        dtack_hist_r;
    logic [3:0]  cs_r;

    logic        start_s;
    region_t     dec_region_s;
    logic        wait_done_s;
    logic        timeout_s;
    logic        irq_load_s;
    logic        unused_write_s;

    // The transfer direction plays no part in decode or cycle timing.
    assign unused_write_s = write_strobe;

    assign {cs_mcd212, cs_cdic, cs_slave, cs_nvram} = cs_r;

    // Cycle start, region decode, per-region completion and timeout qualifiers.
    always_comb begin
        start_s      = as && (uds || lds);
        dec_region_s = decode_region(addr);
        irq_load_s   = (state_r == ST_IDLE) && start_s && (dec_region_s == RG_SLAVE);
        case (region_r)
            RG_MCD212: wait_done_s = mcd212_ack;
            RG_CDIC:   wait_done_s = (wait_cnt_r == CDIC_WAIT_C);
            RG_SLAVE:  wait_done_s = slave_dtack && !dtack_hist_r;
            RG_NVRAM:  wait_done_s = (wait_cnt_r == NVRAM_WAIT_C);
            RG_OPEN:   wait_done_s = (wait_cnt_r == OPEN_WAIT_C);
            default:   wait_done_s = 1'b0;
        endcase
        // The current WAIT cycle is number wait_cnt_r + 1.
        timeout_s = TIMEOUT_EN_C && (({1'b0, wait_cnt_r} + 9'd1) >= TIMEOUT_C);
    end

    // Bus-cycle FSM, wait/IRQ counters, DTACK history and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            region_r     <= RG_OPEN;
            wait_cnt_r   <= 8'd0;
            irq_cnt_r    <= 8'd0;
            dtack_hist_r <= 1'b1;
            cs_r         <= 4'b0000;
            bus_ack      <= 1'b0;
            bus_err      <= 1'b0;
            slave_irq    <= 1'b0;
        end else begin
            // DTACK history runs every cycle so edges outside a slave WAIT are consumed.
            dtack_hist_r <= slave_dtack;

            // IRQ delay runs independently of the FSM; the pulse marks the
            // cycle in which the counter holds 1.
            if (irq_load_s) begin
                irq_cnt_r <= IRQ_DELAY_C;
                slave_irq <= 1'b0;
            end else if (irq_cnt_r != 8'd0) begin
                irq_cnt_r <= irq_cnt_r - 8'd1;
                slave_irq <= (irq_cnt_r == 8'd2);
            end else begin
                irq_cnt_r <= irq_cnt_r;
                slave_irq <= 1'b0;
            end

            bus_ack <= 1'b0;
            bus_err <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        region_r   <= dec_region_s;
                        wait_cnt_r <= 8'd0;
                        if (dec_region_s == RG_ERR) begin
                            state_r <= ST_DONE;
                            bus_err <= 1'b1;
                            cs_r    <= 4'b0000;
                        end else begin
                            state_r <= ST_WAIT;
                            cs_r    <= cs_for_region(dec_region_s);
                        end
                    end else begin
                        state_r <= ST_IDLE;
                        cs_r    <= 4'b0000;
                    end
                end
                ST_WAIT: begin
                    if (!as) begin
                        // CPU abandoned the cycle: no ack, no error.
                        state_r <= ST_IDLE;
                        cs_r    <= 4'b0000;
                    end else if (wait_done_s) begin
                        // Completion beats a simultaneous timeout.
                        state_r <= ST_DONE;
                        bus_ack <= 1'b1;
                    end else if (timeout_s) begin
                        state_r <= ST_DONE;
                        bus_err <= 1'b1;
                        cs_r    <= 4'b0000;
                    end else begin
                        state_r <= ST_WAIT;
                        if (wait_cnt_r != 8'hFF) begin
                            wait_cnt_r <= wait_cnt_r + 8'd1;
                        end else begin
                            wait_cnt_r <= wait_cnt_r;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_HOLD;
                    cs_r    <= 4'b0000;
                end
                ST_HOLD: begin
                    // Wait for the strobes to release so a stretched strobe is acked once.
                    if (!start_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                    cs_r <= 4'b0000;
                end
                default: begin
                    state_r <= ST_IDLE;
                    cs_r    <= 4'b0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Testbench for cpu_bus_ctrl. Cycle 0 of an access is the cycle in which the
// strobe is first presented; outputs are sampled on the falling edge.
module tb_cpu_bus_ctrl;

    localparam int CDIC_WAIT       = 1;
    localparam int NVRAM_WAIT      = 2;
    localparam int OPEN_WAIT       = 1;
    localparam int SLAVE_IRQ_DELAY = 20;
    localparam int TIMEOUT         = 255;

    localparam int K_MCD   = 0;
    localparam int K_CDIC  = 1;
    localparam int K_SLAVE = 2;
    localparam int K_NVRAM = 3;
    localparam int K_OPEN  = 4;
    localparam int K_ERR   = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [22:0] addr;
    logic        as, uds, lds, write_strobe, mcd212_ack, slave_dtack;
    logic        cs_mcd212, cs_cdic, cs_slave, cs_nvram, bus_ack, bus_err, slave_irq;

    int n_checks = 0;
    int n_fail   = 0;
    int now      = 0;
    int irq_due  = -1;

    logic [23:0] b_addr [14] = '{24'h000000, 24'h27FFFE, 24'h280000, 24'h2FFFFE,
                                24'h30FFFE, 24'h33FFFE, 24'h3FFFFE, 24'h400000,
                                24'h5FFFFE, 24'h600000, 24'hCFFFFE, 24'hD00000,
                                24'hEFFFFE, 24'hF00000};
    int          b_kind [14] = '{K_MCD, K_MCD, K_OPEN, K_OPEN,
                                K_CDIC, K_OPEN, K_OPEN, K_MCD,
                                K_MCD, K_ERR, K_ERR, K_OPEN,
                                K_OPEN, K_ERR};

    always #5 clk = ~clk;

    cpu_bus_ctrl #(
        .CDIC_WAIT(CDIC_WAIT), .NVRAM_WAIT(NVRAM_WAIT), .OPEN_WAIT(OPEN_WAIT),
        .SLAVE_IRQ_DELAY(SLAVE_IRQ_DELAY), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .addr(addr), .as(as), .uds(uds), .lds(lds),
        .write_strobe(write_strobe), .mcd212_ack(mcd212_ack), .slave_dtack(slave_dtack),
        .cs_mcd212(cs_mcd212), .cs_cdic(cs_cdic), .cs_slave(cs_slave), .cs_nvram(cs_nvram),
        .bus_ack(bus_ack), .bus_err(bus_err), .slave_irq(slave_irq)
    );

    function automatic logic [5:0] outs();
        return {cs_mcd212, cs_cdic, cs_slave, cs_nvram, bus_ack, bus_err};
    endfunction

    // Cycle of the DONE (ack/err) output, counted from the strobe cycle.
    function automatic int latency(int kind, int ack_at, int edge_at);
        case (kind)
            K_ERR:   return 1;
            K_CDIC:  return 2 + CDIC_WAIT;
            K_NVRAM: return 2 + NVRAM_WAIT;
            K_OPEN:  return 2 + OPEN_WAIT;
            K_MCD:   return ack_at + 1;
            K_SLAVE: return edge_at + 1;
            default: return 1;
        endcase
    endfunction

    // Expected {cs_mcd212, cs_cdic, cs_slave, cs_nvram, bus_ack, bus_err} in cycle j.
    function automatic logic [5:0] expected_outs(int kind, int j, int lat);
        logic [5:0] e;
        e = 6'b000000;
        if (j <= lat) begin
            case (kind)
                K_MCD:   e[5] = 1'b1;
                K_CDIC:  e[4] = 1'b1;
                K_SLAVE: e[3] = 1'b1;
                K_NVRAM: e[2] = 1'b1;
                default: e = e;
            endcase
            if (j == lat) begin
                if (kind == K_ERR) e[0] = 1'b1;
                else               e[1] = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, now);
        end
    endtask

    // Advance one clock; the IRQ pulse is checked on every cycle.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        now++;
        check("slave_irq", 32'(slave_irq), 32'(now == irq_due));
    endtask

    // One complete access: strobe, per-cycle output check, stretched strobe, release.
    task automatic do_access(input string tag, input int kind, input logic [23:0] baddr,
                             input logic wr, input int ack_at, input int edge_at, input int hold);
        int lat;
        lat          = latency(kind, ack_at, edge_at);
        addr         = baddr[23:1];
        as           = 1'b1;
        {uds, lds}   = 2'($urandom_range(1, 3));
        write_strobe = wr;
        mcd212_ack   = 1'b0;
        slave_dtack  = 1'b1;
        if (kind == K_SLAVE) irq_due = now + SLAVE_IRQ_DELAY;
        step();
        for (int j = 1; j <= lat + hold; j++) begin
            check(tag, 32'(outs()), 32'(expected_outs(kind, j, lat)));
            mcd212_ack  = (kind == K_MCD) && (j >= ack_at);
            slave_dtack = !((kind == K_SLAVE) && (j == edge_at - 1));
            if (j == lat + hold) begin
                as  = 1'b0;
                uds = 1'b0;
                lds = 1'b0;
            end
            step();
        end
        check({tag, "_idle"}, 32'(outs()), 32'd0);
        mcd212_ack  = 1'b0;
        slave_dtack = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          kind;
        logic [23:0] ba;

        reset = 1'b1; addr = 23'd0; as = 1'b0; uds = 1'b0; lds = 1'b0;
        write_strobe = 1'b0; mcd212_ack = 1'b0; slave_dtack = 1'b1;
        @(negedge clk);
        step();
        check("reset_outs", 32'(outs()), 32'd0);
        step();
        check("reset_outs2", 32'(outs()), 32'd0);
        reset = 1'b0;
        step();
        check("post_reset_idle", 32'(outs()), 32'd0);

        // as without any data strobe does not start a cycle
        addr = 23'h180008; as = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("no_data_strobe", 32'(outs()), 32'd0);
        end
        as = 1'b0;
        step();

        do_access("cdic_read", K_CDIC, 24'h300010, 1'b0, 0, 0, 4);
        do_access("err_write", K_ERR, 24'h700000, 1'b1, 0, 0, 3);
        do_access("slave_edge", K_SLAVE, 24'h310002, 1'b0, 0, 10, 12);
        do_access("nvram", K_NVRAM, 24'h320100, 1'b1, 0, 0, 2);
        do_access("open", K_OPEN, 24'h350000, 1'b0, 0, 0, 2);

        // MCD212 that never acknowledges
        addr = 23'h100000; as = 1'b1; uds = 1'b1; lds = 1'b0; mcd212_ack = 1'b0;
        step();
`ifdef BUS_TIMEOUT_EN
        for (int j = 1; j <= TIMEOUT + 1; j++) begin
            check("mcd_timeout", 32'(outs()), (j <= TIMEOUT) ? 32'h20 : 32'h01);
            if (j == TIMEOUT + 1) as = 1'b0;
            step();
        end
        check("mcd_timeout_hold", 32'(outs()), 32'd0);
        step();
        check("mcd_timeout_idle", 32'(outs()), 32'd0);
`else
        for (int j = 1; j <= 1000; j++) begin
            check("mcd_stall", 32'(outs()), 32'h20);
            step();
        end
        as = 1'b0;
        step();
        check("mcd_stall_abort", 32'(outs()), 32'd0);
`endif

        // Reset in the middle of an NVRAM WAIT
        addr = 23'h190000; as = 1'b1; uds = 1'b1; lds = 1'b1;
        step();
        check("nvram_wait1", 32'(outs()), 32'h04);
        step();
        check("nvram_wait2", 32'(outs()), 32'h04);
        reset = 1'b1; irq_due = -1;
        step();
        check("mid_reset_outs", 32'(outs()), 32'd0);
        reset = 1'b0; as = 1'b0; uds = 1'b0; lds = 1'b0;
        step();
        check("mid_reset_idle", 32'(outs()), 32'd0);
        do_access("nvram_after_reset", K_NVRAM, 24'h320010, 1'b0, 0, 0, 1);

        // as dropped during an MCD212 WAIT
        addr = 23'h200000; as = 1'b1; uds = 1'b0; lds = 1'b1;
        step();
        check("abort_wait1", 32'(outs()), 32'h20);
        step();
        check("abort_wait2", 32'(outs()), 32'h20);
        as = 1'b0; lds = 1'b0;
        step();
        check("abort_idle1", 32'(outs()), 32'd0);
        step();
        check("abort_idle2", 32'(outs()), 32'd0);
        do_access("mcd_after_abort", K_MCD, 24'h400100, 1'b0, 3, 0, 2);

        // Region boundaries
        for (int i = 0; i < 14; i++) begin
            do_access($sformatf("boundary_%06h", b_addr[i]), b_kind[i], b_addr[i],
                      1'b0, 2, 0, 1);
        end

        // Randomized accesses
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 5));
            case (kind)
                K_MCD: begin
                    if ($urandom_range(0, 1) == 0) ba = 24'($urandom_range(0, 32'h27FFFF));
                    else ba = 24'(32'h400000 + $urandom_range(0, 32'h1FFFFF));
                end
                K_CDIC:  ba = 24'(32'h300000 + $urandom_range(0, 32'hFFFF));
                K_SLAVE: ba = 24'(32'h310000 + $urandom_range(0, 32'hFFFF));
                K_NVRAM: ba = 24'(32'h320000 + $urandom_range(0, 32'hFFFF));
                K_OPEN: begin
                    case ($urandom_range(0, 2))
                        0:       ba = 24'(32'h280000 + $urandom_range(0, 32'h7FFFF));
                        1:       ba = 24'(32'h330000 + $urandom_range(0, 32'hCFFFF));
                        default: ba = 24'(32'hD00000 + $urandom_range(0, 32'h1FFFFF));
                    endcase
                end
                default: begin
                    if ($urandom_range(0, 1) == 0) ba = 24'(32'h600000 + $urandom_range(0, 32'h6FFFFF));
                    else ba = 24'(32'hF00000 + $urandom_range(0, 32'hFFFFF));
                end
            endcase
            ba[0] = 1'b0;
            do_access($sformatf("rand_%0d_k%0d", n, kind), kind, ba,
                      1'($urandom_range(0, 1)), int'($urandom_range(1, 6)),
                      int'($urandom_range(2, 8)), int'($urandom_range(1, 4)));
        end

        // Let any pending slave IRQ expire under observation
        for (int k = 0; k < SLAVE_IRQ_DELAY + 2; k++) begin
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
